gameover_image_reader: RTL and testbench

Read-side client of the 480×360 game-over image ROM. It sits between the VGA timing generator and the colour output mux. It converts the current scan coordinates into sequential ROM addresses for a centred image window and absorbs the ROM's one-clock read latency. It emits an aligned 8-bit pixel, or a background colour outside the window. Display is armed by game-over logic and only starts on a frame boundary, so no partial first frame is drawn.

---
 rtl/piano_tiles_pkg.sv | 22 ++
 rtl/gameover_image_reader_if.sv | 28 ++
 rtl/gameover_addr_gen.sv | 92 +++++++++
 rtl/gameover_image_reader.sv | 113 +++++++++++
 tb/tb_gameover_image_reader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/piano_tiles_pkg.sv
// piano_tiles_pkg: screen geometry, game-over image placement and the
// state encoding shared by the game-over image reader.
package piano_tiles_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    localparam int GO_IMG_W  = 480;
    localparam int GO_IMG_H  = 360;
    localparam int GO_X0     = 80;
    localparam int GO_Y0     = 60;
    localparam int GO_ADDR_W = 18;

    localparam logic [7:0] BG_COLOR = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHOW  = 2'd2
    } go_state_t;

endpackage

// File: rtl/gameover_image_reader_if.sv
// gameover_image_reader_if: scan position from the VGA timing generator,
// the image ROM read port and the aligned pixel outputs.
// master = timing generator / ROM / colour mux side, slave = the reader.
interface gameover_image_reader_if #(
    parameter int ADDR_W = piano_tiles_pkg::GO_ADDR_W
);
    logic              i_pix_tick;
    logic [9:0]        i_x;
    logic [9:0]        i_y;
    logic              i_video_on;
    logic              i_show;
    logic [ADDR_W-1:0] o_rom_addr;
    logic [7:0]        i_rom_data;
    logic [7:0]        o_pixel;
    logic              o_video_on;
    logic              o_active;
    logic              o_addr_err;

    modport slave (
        input  i_pix_tick, i_x, i_y, i_video_on, i_show, i_rom_data,
        output o_rom_addr, o_pixel, o_video_on, o_active, o_addr_err
    );

    modport master (
        output i_pix_tick, i_x, i_y, i_video_on, i_show, i_rom_data,
        input  o_rom_addr, o_pixel, o_video_on, o_active, o_addr_err
    );
endinterface

// File: rtl/gameover_addr_gen.sv
// gameover_addr_gen: window compare, row-major ROM address counter and the
// sticky address-consistency checker for the game-over image.
module gameover_addr_gen import piano_tiles_pkg::*; #(
    parameter int IMG_W  = GO_IMG_W,
    parameter int IMG_H  = GO_IMG_H,
    parameter int X0     = GO_X0,
    parameter int Y0     = GO_Y0,
    parameter int ADDR_W = GO_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pix_tick_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic              video_on_i,
    input  logic              show_st_i,
    output logic              in_win_o,
    output logic              frame_start_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              addr_err_o
);
    localparam logic [9:0] X_LO   = 10'(X0);
    localparam logic [9:0] X_HI   = 10'(X0 + IMG_W);
    localparam logic [9:0] X_LAST = 10'(X0 + IMG_W - 1);
    localparam logic [9:0] Y_LO   = 10'(Y0);
    localparam logic [9:0] Y_HI   = 10'(Y0 + IMG_H);
    localparam logic [9:0] Y_LAST = 10'(Y0 + IMG_H - 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] TOTAL     = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic              in_win_s;
    logic              frame_start_s;
    logic              inc_s;
    logic              at_last_s;
    logic              err_set_s;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              err_q, err_d;

    assign in_win_s      = video_on_i &&
                           (x_i >= X_LO) && (x_i < X_HI) &&
                           (y_i >= Y_LO) && (y_i < Y_HI);
    assign frame_start_s = pix_tick_i && (x_i == 10'd0) && (y_i == 10'd0);
    assign inc_s         = pix_tick_i && in_win_s && show_st_i && !frame_start_s;
    assign at_last_s     = inc_s && (x_i == X_LAST) && (y_i == Y_LAST);

    // The last window pixel must see the last address. Stepping onto TOTAL
    // anywhere else, or trying to step past it, means ticks were gained or lost.
    assign err_set_s = (at_last_s && (cnt_q != LAST_ADDR)) ||
                       (inc_s && !at_last_s && (cnt_q == LAST_ADDR)) ||
                       (inc_s && (cnt_q == TOTAL));

    // Counter, address register and error flag next-state values
    always_comb begin
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        err_d      = err_q | err_set_s;
        if (frame_start_s) begin
            cnt_d = {ADDR_W{1'b0}};
        end else if (inc_s && (cnt_q != TOTAL)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (in_win_s) begin
            rom_addr_d = cnt_q;
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // Address counter, registered ROM address and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= {ADDR_W{1'b0}};
            rom_addr_q <= {ADDR_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            err_q      <= err_d;
        end
    end

    assign in_win_o      = in_win_s;
    assign frame_start_o = frame_start_s;
    assign rom_addr_o    = rom_addr_q;
    assign addr_err_o    = err_q;

endmodule

// File: rtl/gameover_image_reader.sv
// gameover_image_reader: arms on the game-over request, starts drawing on a
// frame boundary and returns ROM pixels aligned 3 clocks after the scan
// coordinates, with a background colour outside the image window.
module gameover_image_reader import piano_tiles_pkg::*; #(
    parameter int         IMG_W    = GO_IMG_W,
    parameter int         IMG_H    = GO_IMG_H,
    parameter int         X0       = GO_X0,
    parameter int         Y0       = GO_Y0,
    parameter int         ADDR_W   = GO_ADDR_W,
    parameter logic [7:0] BG_COLOR = piano_tiles_pkg::BG_COLOR
) (
    input  logic                   i_clk2,
    input  logic                   i_rst_n,
    gameover_image_reader_if.slave bus
);
    go_state_t         state_q, state_d;
    logic              in_win_s;
    logic              frame_start_s;
    logic              show_st_s;
    logic              win_s;
    logic [ADDR_W-1:0] rom_addr_s;
    logic              addr_err_s;
    logic              active_q;
    logic              win_d1_q, win_d2_q;
    logic              von_d1_q, von_d2_q, von_d3_q;
    logic [7:0]        pixel_q, pixel_d;

    assign show_st_s = (state_q == SHOW);
    assign win_s     = in_win_s && show_st_s;

    gameover_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .X0     (X0),
        .Y0     (Y0),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i         (i_clk2),
        .rst_ni        (i_rst_n),
        .pix_tick_i    (bus.i_pix_tick),
        .x_i           (bus.i_x),
        .y_i           (bus.i_y),
        .video_on_i    (bus.i_video_on),
        .show_st_i     (show_st_s),
        .in_win_o      (in_win_s),
        .frame_start_o (frame_start_s),
        .rom_addr_o    (rom_addr_s),
        .addr_err_o    (addr_err_s)
    );

    // Next state: a dropped request always wins; SHOW only begins on frame_start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.i_show) state_d = ARMED;
                else            state_d = IDLE;
            end
            ARMED: begin
                if (!bus.i_show)        state_d = IDLE;
                else if (frame_start_s) state_d = SHOW;
                else                    state_d = ARMED;
            end
            SHOW: begin
                if (!bus.i_show) state_d = IDLE;
                else             state_d = SHOW;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output mux: ROM data lines up with win_d2, background with von_d2
    always_comb begin
        pixel_d = 8'h00;
        if (win_d2_q) begin
            pixel_d = bus.i_rom_data;
        end else if (von_d2_q) begin
            pixel_d = BG_COLOR;
        end else begin
            pixel_d = 8'h00;
        end
    end

    // State register and the free-running alignment pipeline
    always_ff @(posedge i_clk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            win_d1_q <= 1'b0;
            win_d2_q <= 1'b0;
            von_d1_q <= 1'b0;
            von_d2_q <= 1'b0;
            von_d3_q <= 1'b0;
            pixel_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == SHOW);
            win_d1_q <= win_s;
            win_d2_q <= win_d1_q;
            von_d1_q <= bus.i_video_on;
            von_d2_q <= von_d1_q;
            von_d3_q <= von_d2_q;
            pixel_q  <= pixel_d;
        end
    end

    assign bus.o_rom_addr = rom_addr_s;
    assign bus.o_pixel    = pixel_q;
    assign bus.o_video_on = von_d3_q;
    assign bus.o_active   = active_q;
    assign bus.o_addr_err = addr_err_s;

endmodule

// File: tb/tb_gameover_image_reader.sv
// tb_gameover_image_reader: scans a reduced screen (80x53 total, 64x48
// visible) with a 48x36 image at (8,6) so that whole frames stay short.
// A ROM model returns addr[7:0]; expected pixels go into a scoreboard queue
// when coordinates are driven and are compared 3 clocks later.
module tb_gameover_image_reader;
    import piano_tiles_pkg::*;

    localparam int W      = 48;
    localparam int H      = 36;
    localparam int XO     = 8;
    localparam int YO     = 6;
    localparam int H_TOT  = 80;
    localparam int H_VIS  = 64;
    localparam int V_TOT  = 53;
    localparam int V_VIS  = 48;
    localparam int LAST   = W * H - 1;
    localparam logic [7:0] BG = 8'hA5;

    typedef struct {
        int         due;
        logic [7:0] pix;
        logic       von;
    } exp_t;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    exp_t      sb[$];
    int        n_vec = 0;
    int        n_err = 0;
    int        cyc   = 0;
    go_state_t m_state;
    logic      m_err;
    bit        skip_done;
    int        ev_a_x, ev_a_y, ev_b_x, ev_b_y, ev_r_x, ev_r_y;
    logic      ev_a_val, ev_b_val;

    gameover_image_reader_if bus();

    gameover_image_reader #(
        .IMG_W    (W),
        .IMG_H    (H),
        .X0       (XO),
        .Y0       (YO),
        .ADDR_W   (18),
        .BG_COLOR (BG)
    ) dut (
        .i_clk2  (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ROM model: one-clock read latency, data = low address byte
    always @(posedge clk) bus.i_rom_data <= bus.o_rom_addr[7:0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string addr_tag(input int x, input int y);
        if (x == XO && y == YO)                 return "addr_first";
        if (x == XO + W - 1 && y == YO)         return "addr_row0_end";
        if (x == XO && y == YO + 1)             return "addr_row1_start";
        if (x == XO + W - 1 && y == YO + H - 1) return "addr_last";
        return "rom_addr";
    endfunction

    task automatic clock_px(input int x, input int y, input bit tick, input bit von);
        go_state_t nxt;
        bit        in_win, fs, win;
        int        ea;
        exp_t      e;
        bus.i_x        = 10'(x);
        bus.i_y        = 10'(y);
        bus.i_pix_tick = tick;
        bus.i_video_on = von;
        in_win = von && x >= XO && x < XO + W && y >= YO && y < YO + H;
        fs     = tick && x == 0 && y == 0;
        win    = in_win && (m_state == SHOW);
        ea     = (y - YO) * W + (x - XO) - (skip_done ? 1 : 0);
        e.due  = cyc + 3;
        e.pix  = win ? 8'(ea) : (von ? BG : 8'h00);
        e.von  = von;
        sb.push_back(e);
        nxt = m_state;
        case (m_state)
            IDLE:    if (bus.i_show) nxt = ARMED;
            ARMED:   if (!bus.i_show) nxt = IDLE; else if (fs) nxt = SHOW;
            SHOW:    if (!bus.i_show) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (win && tick && x == XO + W - 1 && y == YO + H - 1 && ea != LAST) m_err = 1'b1;
        if (fs) skip_done = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        m_state = nxt;
        if (win) check_eq(addr_tag(x, y), 32'(bus.o_rom_addr), 32'(ea));
        check_eq("active", 32'(bus.o_active), 32'(m_state == SHOW));
        check_eq("addr_err", 32'(bus.o_addr_err), 32'(m_err));
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check_eq("pixel", 32'(bus.o_pixel), 32'(e.pix));
            check_eq("video_on", 32'(bus.o_video_on), 32'(e.von));
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check_eq("rst_pixel", 32'(bus.o_pixel), 32'h0);
        check_eq("rst_video_on", 32'(bus.o_video_on), 32'h0);
        check_eq("rst_active", 32'(bus.o_active), 32'h0);
        check_eq("rst_addr_err", 32'(bus.o_addr_err), 32'h0);
        check_eq("rst_rom_addr", 32'(bus.o_rom_addr), 32'h0);
        sb.delete();
        m_state   = IDLE;
        m_err     = 1'b0;
        skip_done = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic clear_events();
        ev_a_x = -1; ev_a_y = -1; ev_a_val = 1'b0;
        ev_b_x = -1; ev_b_y = -1; ev_b_val = 1'b0;
        ev_r_x = -1; ev_r_y = -1;
    endtask

    task automatic scan_frame(input int cpp, input int skip_x, input int skip_y);
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                if (x == ev_r_x && y == ev_r_y) reset_pulse();
                if (x == ev_a_x && y == ev_a_y) bus.i_show = ev_a_val;
                if (x == ev_b_x && y == ev_b_y) bus.i_show = ev_b_val;
                for (int k = 0; k < cpp; k++) begin
                    clock_px(x, y, (k == cpp - 1) && !(x == skip_x && y == skip_y),
                             (x < H_VIS) && (y < V_VIS));
                end
                if (x == skip_x && y == skip_y) skip_done = 1'b1;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_pix_tick = 1'b0;
        bus.i_x        = 10'd0;
        bus.i_y        = 10'd0;
        bus.i_video_on = 1'b0;
        bus.i_show     = 1'b0;
        m_state        = IDLE;
        m_err          = 1'b0;
        skip_done      = 1'b0;
        clear_events();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_pixel", 32'(bus.o_pixel), 32'h0);
        check_eq("reset_video_on", 32'(bus.o_video_on), 32'h0);
        check_eq("reset_active", 32'(bus.o_active), 32'h0);
        check_eq("reset_addr_err", 32'(bus.o_addr_err), 32'h0);
        check_eq("reset_rom_addr", 32'(bus.o_rom_addr), 32'h0);
        rst_n = 1'b1;

        // Idle frame: background only, never active
        scan_frame(1, -1, -1);

        // Arm mid-frame: stays ARMED and draws nothing until the next frame
        ev_a_x = 40; ev_a_y = 30; ev_a_val = 1'b1;
        scan_frame(1, -1, -1);
        clear_events();

        // Full image frame at one clock per pixel
        scan_frame(1, -1, -1);

        // Full image frame at two clocks per pixel
        scan_frame(2, -1, -1);

        // Drop inside the window, then re-arm within the same frame
        ev_a_x = 20; ev_a_y = 15; ev_a_val = 1'b0;
        ev_b_x = 30; ev_b_y = 25; ev_b_val = 1'b1;
        scan_frame(1, -1, -1);
        clear_events();

        // Reset in the middle of a showing frame with i_show held high
        ev_r_x = 30; ev_r_y = 20;
        scan_frame(1, -1, -1);
        clear_events();

        // Suppressed tick inside the window flags an address error
        scan_frame(1, 10, 7);
        check_eq("err_after_frame", 32'(bus.o_addr_err), 32'h1);

        // Error is sticky across the next frame start, cleared only by reset
        for (int x = 0; x < 6; x++) clock_px(x, 0, 1'b1, 1'b1);
        reset_pulse();
        bus.i_show = 1'b0;
        for (int k = 0; k < 6; k++) clock_px(70, 50, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
